ct_rtu_onehot_ptr: RTL and testbench
====================================

// Module: ct_rtu_onehot_ptr
// PURPOSE
// - Registered circular pointer for RTU queues (ROB/PST create and retire pointers), held in
//   one-hot and binary form at once, with a wrap bit for full/empty detection.
// - Advances by 0..MAX_INC entries per cycle. Loads directly on flush/recovery.
// - Supplies one-hot lookahead pointers ptr+1..ptr+MAX_INC, so multi-entry create logic needs
//   no decoders of its own.
// PARAMETERS
// - DEPTH    32  queue entries; any value >= 2, power of two not required
// - PTR_W    $clog2(DEPTH)  binary pointer width (derived, not overridden)
// - MAX_INC  4   maximum advance per cycle; 1 <= MAX_INC < DEPTH
// - INC_W    $clog2(MAX_INC+1)  width of advance count (derived)
// PORTS
// - forever_cpuclk      in   1              core clock
// - cpurst              in   1              synchronous active-high reset
// - x_load_vld          in   1              load pointer (flush/recovery)
// - x_load_num          in   PTR_W          load value; must be < DEPTH
// - x_load_wrap         in   1              load wrap bit
// - x_inc_vld           in   1              advance request
// - x_inc_num           in   INC_W          advance count 0..MAX_INC
// - x_ptr_onehot        out  DEPTH          current pointer, one-hot
// - x_ptr_num           out  PTR_W          current pointer, binary
// - x_ptr_wrap          out  1              wrap bit; toggles on each pass through entry 0
// - x_ptr_ahead_onehot  out  MAX_INC*DEPTH  slice k-1 = one-hot of (ptr+k) mod DEPTH, k=1..MAX_INC
// - x_ptr_err           out  1              sticky error flag
// BEHAVIOUR
// - Reset (sync, cpurst=1 at posedge):
//   - onehot = 1 (bit 0), num = 0, wrap = 0, err = 0.
//   - Reset overrides load and inc in the same cycle.
// - All state is registered. Updates are visible the cycle after the request; no combinational
//   path from inputs to x_ptr_*.
// - Priority: reset > load > inc.
//   - Load: onehot = decode(x_load_num), num = x_load_num, wrap = x_load_wrap.
//   - A simultaneous inc is discarded.
// - Inc (x_inc_vld=1, x_inc_num <= MAX_INC):
//   - sum = num + x_inc_num (PTR_W+1 bits).
//   - If sum >= DEPTH: num = sum - DEPTH and wrap toggles. Otherwise num = sum.
//   - onehot is rotated left by x_inc_num modulo DEPTH, i.e. bit (DEPTH-1) rotates into bit 0.
//   - inc_num = 0 is legal and leaves the state unchanged.
// - Illegal inc (x_inc_vld=1, x_inc_num > MAX_INC): state holds and err is set.
// - Illegal load (x_load_vld=1, x_load_num >= DEPTH): state holds and err is set.
// - Integrity check, every cycle: if the registered onehot is not exactly one-hot, or
//   onehot != decode(num), err is set.
// - err clears only on reset.
// - x_ptr_ahead_onehot is combinational from the registered onehot (fixed rotations, no adders).
//   Entries wrap modulo DEPTH with no wrap-bit information.
// - Idle (no load, no inc): all state holds.
// STRUCTURE
// - Sub-module ct_rtu_expand_n: parametrised binary->one-hot decoder, ports x_num[PTR_W] and
//   x_num_expand[DEPTH]; bits >= DEPTH read as all-zero. Instantiated twice: once for the load
//   path, once for the integrity compare.
// - Package ct_rtu_ptr_pkg:
//   - function rot_left_onehot(vec, amount, depth)
//   - function is_onehot(vec)
//   - localparam defaults RTU_ROB_DEPTH = 32, RTU_MAX_CREATE = 4
// - No FSM. The state is {onehot, num, wrap, err}.
// TESTING (DEPTH=32, MAX_INC=4 unless noted)
// - Reset -> onehot=0x0000_0001, num=0, wrap=0, err=0, ahead slices = 0x2,0x4,0x8,0x10.
// - Load num=30, wrap=0; next cycle inc 3 -> num=1, wrap=1, onehot=0x0000_0002,
//   ahead[0]=0x4; err=0.
// - Load num=5 and inc 2 in the same cycle -> num=5, onehot=0x20 (load wins).
// - inc_num=5 at num=7 -> num stays 7, err=1; err stays 1 until reset.
// - DEPTH=24: num=22, inc 3 -> num=1, wrap toggles, onehot bit1. Load num=24 -> state holds,
//   err=1.
// - Reset asserted with inc 4 pending at num=10 -> num=0, wrap=0, onehot=1. Random
//   inc/load stream vs. reference model, with onehot==decode(num) checked every cycle.

Source files
------------

// File: rtl/ct_rtu_ptr_pkg.sv
// Shared definitions for the RTU circular pointers: default sizes and the
// generic one-hot helpers. The helpers work on a wide carrier vector so one
// function serves every DEPTH; callers widen the input and narrow the result.
package ct_rtu_ptr_pkg;

  localparam int RTU_ROB_DEPTH  = 32;
  localparam int RTU_MAX_CREATE = 4;

  // Widest queue the helpers support, and the index width into that carrier.
  localparam int RTU_VEC_W = 1024;
  localparam int RTU_IDX_W = $clog2(RTU_VEC_W);

  // Rotate the low 'depth' bits of vec left by 'amount'; bit depth-1 wraps
  // into bit 0. Bits at or above 'depth' come back as zero.
  function automatic logic [RTU_VEC_W-1:0] rot_left_onehot(
    input logic [RTU_VEC_W-1:0] vec,
    input int                   amount,
    input int                   depth
  );
    logic [RTU_VEC_W-1:0] res;
    res = '0;
    for (int i = 0; i < RTU_VEC_W; i++) begin
      if (i < depth) begin
        res[RTU_IDX_W'((i + amount) % depth)] = vec[RTU_IDX_W'(i)];
      end
    end
    return res;
  endfunction

  // True when exactly one bit of vec is set.
  function automatic logic is_onehot(input logic [RTU_VEC_W-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < RTU_VEC_W; i++) begin
      cnt = cnt + int'(vec[RTU_IDX_W'(i)]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/ct_rtu_onehot_ptr_if.sv
// Request/response bundle of the RTU one-hot pointer. The pointer block is
// the slave: it takes load/advance requests and returns the pointer views.
interface ct_rtu_onehot_ptr_if
  import ct_rtu_ptr_pkg::*;
#(
  parameter int DEPTH   = RTU_ROB_DEPTH,
  parameter int MAX_INC = RTU_MAX_CREATE
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int INC_W = $clog2(MAX_INC + 1);

  logic                     x_load_vld;
  logic [PTR_W-1:0]         x_load_num;
  logic                     x_load_wrap;
  logic                     x_inc_vld;
  logic [INC_W-1:0]         x_inc_num;
  logic [DEPTH-1:0]         x_ptr_onehot;
  logic [PTR_W-1:0]         x_ptr_num;
  logic                     x_ptr_wrap;
  logic [MAX_INC*DEPTH-1:0] x_ptr_ahead_onehot;
  logic                     x_ptr_err;

  modport master (
    output x_load_vld, x_load_num, x_load_wrap, x_inc_vld, x_inc_num,
    input  x_ptr_onehot, x_ptr_num, x_ptr_wrap, x_ptr_ahead_onehot, x_ptr_err
  );

  modport slave (
    input  x_load_vld, x_load_num, x_load_wrap, x_inc_vld, x_inc_num,
    output x_ptr_onehot, x_ptr_num, x_ptr_wrap, x_ptr_ahead_onehot, x_ptr_err
  );

endinterface

// File: rtl/ct_rtu_expand_n.sv
// Binary to one-hot decoder. Codes at or above DEPTH decode to all-zero.
module ct_rtu_expand_n #(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0] x_num,
  output logic [DEPTH-1:0] x_num_expand
);

  // One comparator per entry; an out-of-range code matches none of them.
  always_comb begin
    x_num_expand = '0;
    for (int i = 0; i < DEPTH; i++) begin
      x_num_expand[i] = (x_num == PTR_W'(i));
    end
  end

endmodule

// File: rtl/ct_rtu_onehot_ptr.sv
// Registered circular queue pointer kept in one-hot and binary form with a
// wrap bit. Advances 0..MAX_INC per cycle, loads on flush/recovery, and
// offers one-hot lookahead pointers ptr+1..ptr+MAX_INC.
module ct_rtu_onehot_ptr
  import ct_rtu_ptr_pkg::*;
#(
  parameter  int DEPTH   = RTU_ROB_DEPTH,
  parameter  int MAX_INC = RTU_MAX_CREATE,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int INC_W   = $clog2(MAX_INC + 1)
) (
  input logic                forever_cpuclk,
  input logic                cpurst,
  ct_rtu_onehot_ptr_if.slave x
);

  localparam logic [PTR_W:0]   DEPTH_EXT = (PTR_W + 1)'(DEPTH);
  localparam logic [INC_W-1:0] MAX_INC_C = INC_W'(MAX_INC);

  logic [DEPTH-1:0] onehot_q, onehot_d;
  logic [PTR_W-1:0] num_q, num_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [DEPTH-1:0]         load_dec;
  logic [DEPTH-1:0]         num_dec;
  logic [PTR_W:0]           sum;
  logic                     load_ok;
  logic                     inc_ok;
  logic                     integrity_bad;
  logic [MAX_INC*DEPTH-1:0] ahead;

  ct_rtu_expand_n #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_load_expand (
    .x_num        (x.x_load_num),
    .x_num_expand (load_dec)
  );

  ct_rtu_expand_n #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_chk_expand (
    .x_num        (num_q),
    .x_num_expand (num_dec)
  );

  assign load_ok       = ({1'b0, x.x_load_num} < DEPTH_EXT);
  assign inc_ok        = (x.x_inc_num <= MAX_INC_C);
  assign sum           = {1'b0, num_q} + (PTR_W + 1)'(x.x_inc_num);
  assign integrity_bad = !is_onehot(RTU_VEC_W'(onehot_q)) || (onehot_q != num_dec);

  // Next state: load beats advance; an illegal request holds state and flags err.
  always_comb begin
    onehot_d = onehot_q;
    num_d    = num_q;
    wrap_d   = wrap_q;
    err_d    = err_q | integrity_bad;
    if (x.x_load_vld) begin
      if (load_ok) begin
        onehot_d = load_dec;
        num_d    = x.x_load_num;
        wrap_d   = x.x_load_wrap;
      end else begin
        err_d = 1'b1;
      end
    end else if (x.x_inc_vld) begin
      if (inc_ok) begin
        onehot_d = DEPTH'(rot_left_onehot(RTU_VEC_W'(onehot_q), int'(x.x_inc_num), DEPTH));
        if (sum >= DEPTH_EXT) begin
          num_d  = PTR_W'(sum - DEPTH_EXT);
          wrap_d = ~wrap_q;
        end else begin
          num_d = sum[PTR_W-1:0];
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Pointer state register; reset parks the pointer at entry 0 and clears err.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      onehot_q <= DEPTH'(1);
      num_q    <= '0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      num_q    <= num_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  // Lookahead pointers are fixed rotations of the registered one-hot.
  for (genvar k = 1; k <= MAX_INC; k++) begin : g_ahead
    assign ahead[(k-1)*DEPTH +: DEPTH] = {onehot_q[DEPTH-1-k:0], onehot_q[DEPTH-1:DEPTH-k]};
  end

  assign x.x_ptr_onehot       = onehot_q;
  assign x.x_ptr_num          = num_q;
  assign x.x_ptr_wrap         = wrap_q;
  assign x.x_ptr_err          = err_q;
  assign x.x_ptr_ahead_onehot = ahead;

endmodule

// File: tb/tb_ct_rtu_onehot_ptr.sv
// Bench for ct_rtu_onehot_ptr: a DEPTH=32 and a DEPTH=24 instance, driven by
// directed and random requests; a position-based model predicts each cycle's
// state and a monitor compares it against the DUT outputs.
module tb_ct_rtu_onehot_ptr;

  logic clk;
  logic rst32, rst24;

  ct_rtu_onehot_ptr_if #(.DEPTH(32), .MAX_INC(4)) if32 ();
  ct_rtu_onehot_ptr_if #(.DEPTH(24), .MAX_INC(4)) if24 ();

  ct_rtu_onehot_ptr #(.DEPTH(32), .MAX_INC(4)) u_dut32 (
    .forever_cpuclk (clk),
    .cpurst         (rst32),
    .x              (if32.slave)
  );

  ct_rtu_onehot_ptr #(.DEPTH(24), .MAX_INC(4)) u_dut24 (
    .forever_cpuclk (clk),
    .cpurst         (rst24),
    .x              (if24.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  oh;
    logic [4:0]   num;
    logic         wrap;
    logic         err;
    logic [127:0] ahead;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int nchk = 0;
  int nbad = 0;

  // Model: linear position 0..2*D-1 (wrap = upper half), plus sticky err.
  int mpos[2];
  bit merr[2];
  int dep[2] = '{32, 24};

  task automatic model_step(int d, bit r, bit lv, int ln, bit lw, bit iv, int in);
    int D;
    D = dep[d];
    if (r) begin
      mpos[d] = 0;
      merr[d] = 0;
    end else if (lv) begin
      if (ln < D) mpos[d] = ln + (lw ? D : 0);
      else        merr[d] = 1;
    end else if (iv) begin
      if (in <= 4) mpos[d] = (mpos[d] + in) % (2 * D);
      else         merr[d] = 1;
    end
  endtask

  function automatic exp_t mk(int d);
    exp_t e;
    int D, n;
    D = dep[d];
    n = mpos[d] % D;
    e.oh = '0;
    e.oh[n] = 1'b1;
    e.num = 5'(n);
    e.wrap = (mpos[d] >= D);
    e.err = merr[d];
    e.ahead = '0;
    for (int k = 1; k <= 4; k++) e.ahead[(k - 1) * D + (n + k) % D] = 1'b1;
    return e;
  endfunction

  task automatic cyc(int d, bit r, bit lv, int ln, bit lw, bit iv, int in);
    @(negedge clk);
    rst32 = 0; if32.x_load_vld = 0; if32.x_inc_vld = 0;
    rst24 = 0; if24.x_load_vld = 0; if24.x_inc_vld = 0;
    if (d == 0) begin
      rst32 = r; if32.x_load_vld = lv; if32.x_load_num = 5'(ln);
      if32.x_load_wrap = lw; if32.x_inc_vld = iv; if32.x_inc_num = 3'(in);
    end else begin
      rst24 = r; if24.x_load_vld = lv; if24.x_load_num = 5'(ln);
      if24.x_load_wrap = lw; if24.x_inc_vld = iv; if24.x_inc_num = 3'(in);
    end
    model_step(d, r, lv, ln, lw, iv, in);
    if (d == 0) q0.push_back(mk(0));
    else        q1.push_back(mk(1));
  endtask

  task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
    nchk++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  // Monitor: after each edge, compare whatever the driver predicted for it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("d32.onehot", 128'(if32.x_ptr_onehot), 128'(e.oh));
      chk("d32.num",    128'(if32.x_ptr_num), 128'(e.num));
      chk("d32.wrap",   128'(if32.x_ptr_wrap), 128'(e.wrap));
      chk("d32.err",    128'(if32.x_ptr_err), 128'(e.err));
      chk("d32.ahead",  128'(if32.x_ptr_ahead_onehot), e.ahead);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("d24.onehot", 128'(if24.x_ptr_onehot), 128'(e.oh));
      chk("d24.num",    128'(if24.x_ptr_num), 128'(e.num));
      chk("d24.wrap",   128'(if24.x_ptr_wrap), 128'(e.wrap));
      chk("d24.err",    128'(if24.x_ptr_err), 128'(e.err));
      chk("d24.ahead",  128'(if24.x_ptr_ahead_onehot), e.ahead);
    end
  end

  initial begin
    rst32 = 1; rst24 = 1;
    if32.x_load_vld = 0; if32.x_load_num = '0; if32.x_load_wrap = 0;
    if32.x_inc_vld = 0; if32.x_inc_num = '0;
    if24.x_load_vld = 0; if24.x_load_num = '0; if24.x_load_wrap = 0;
    if24.x_inc_vld = 0; if24.x_inc_num = '0;
    mpos = '{0, 0};
    merr = '{0, 0};

    // DEPTH=32 directed
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 30, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 3);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 5, 0, 1, 2);
    cyc(0, 0, 1, 7, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 5);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 1, 3, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 10, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 4);
    cyc(0, 0, 1, 31, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);

    // DEPTH=24 directed
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 22, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 3);
    cyc(1, 0, 1, 23, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 4);
    cyc(1, 0, 1, 24, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 2);

    // Random streams
    for (int i = 0; i < 400; i++) begin
      cyc(0, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15, $urandom_range(0, 31),
          1'($urandom_range(0, 1)), $urandom_range(0, 99) < 65,
          ($urandom_range(0, 99) < 4) ? $urandom_range(5, 7) : $urandom_range(0, 4));
    end
    for (int i = 0; i < 400; i++) begin
      cyc(1, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15,
          ($urandom_range(0, 99) < 5) ? $urandom_range(24, 31) : $urandom_range(0, 23),
          1'($urandom_range(0, 1)), $urandom_range(0, 99) < 65,
          ($urandom_range(0, 99) < 3) ? $urandom_range(5, 7) : $urandom_range(0, 4));
    end

    @(negedge clk);
    rst32 = 0; if32.x_load_vld = 0; if32.x_inc_vld = 0;
    rst24 = 0; if24.x_load_vld = 0; if24.x_inc_vld = 0;
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
